// File: rtl/contador_pkg.sv
// Default constants for the contador_rst bit counter.
package contador_pkg;
    localparam int CONTADOR_MAX_DEF   = 9;
    localparam int CONTADOR_WIDTH_DEF = 4;
endpackage

// File: rtl/contador_rst.sv
// Serial-bus bit counter: counts 1..MAX and wraps to 1, so 0 appears only after reset; one-edge latency, En=0 holds.
// Define CONTADOR_TC_EN to add the combinational terminal-count output Tc.
module contador_rst
    import contador_pkg::*;
#(
    parameter int MAX   = CONTADOR_MAX_DEF,
    parameter int WIDTH = CONTADOR_WIDTH_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
`ifdef CONTADOR_TC_EN
    output logic             Tc,
`endif
    output logic [WIDTH-1:0] Out
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    if (MAX < 1 || MAX > (2 ** WIDTH) - 1) begin : g_bad_max
        $error("contador_rst: MAX must lie in 1..2**WIDTH-1");
    end

    // Wrap to 1 rather than 0 so every 9-clock frame after the first spans 1..MAX;
    // the >= also recovers from any out-of-range value on the next enabled edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Out <= '0;
        end else if (En) begin
            Out <= (Out >= MAX_V) ? WIDTH'(1) : Out + WIDTH'(1);
        end
    end

`ifdef CONTADOR_TC_EN
    assign Tc = (Out == MAX_V);
`endif

endmodule

// File: tb/tb_contador_rst.sv
// Bench for contador_rst: default MAX=9/WIDTH=4 instance plus a MAX=3/WIDTH=2 instance on shared stimulus.
module tb_contador_rst;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] out0;
    logic [1:0] out1;
`ifdef CONTADOR_TC_EN
    logic       tc0;
    logic       tc1;
`endif

    int checks = 0;
    int errors = 0;
    int m0 = 0;
    int m1 = 0;

    always #5 clk = ~clk;

    contador_rst dut0 (
        .Clk (clk),
        .Rst (rst),
        .En  (en),
`ifdef CONTADOR_TC_EN
        .Tc  (tc0),
`endif
        .Out (out0)
    );

    contador_rst #(.MAX(3), .WIDTH(2)) dut1 (
        .Clk (clk),
        .Rst (rst),
        .En  (en),
`ifdef CONTADOR_TC_EN
        .Tc  (tc1),
`endif
        .Out (out1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: reset gives 0, each enabled edge gives (n mod MAX) + 1.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m0 = 0;
            m1 = 0;
        end else if (en) begin
            m0 = (m0 % 9) + 1;
            m1 = (m1 % 3) + 1;
        end
    end

    always @(negedge clk) begin
        chk("model_out0", int'(out0), m0);
        chk("model_out1", int'(out1), m1);
`ifdef CONTADOR_TC_EN
        chk("model_tc0", int'(tc0), int'(m0 == 9));
        chk("model_tc1", int'(tc1), int'(m1 == 3));
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seq1 [6] = '{1, 2, 3, 1, 2, 3};

        rst = 1'b1;
        en  = 1'b0;
        repeat (2) tick();
        chk("reset_out0", int'(out0), 0);
        chk("reset_out1", int'(out1), 0);
`ifdef CONTADOR_TC_EN
        chk("reset_tc0", int'(tc0), 0);
`endif
        rst = 1'b0;
        en  = 1'b1;

        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("ramp_out0", int'(out0), i);
            if (i <= 6) chk("small_out1", int'(out1), seq1[i-1]);
        end
        tick();
        chk("edge9_out0", int'(out0), 9);
`ifdef CONTADOR_TC_EN
        chk("edge9_tc0", int'(tc0), 1);
`endif
        tick();
        chk("edge10_wrap", int'(out0), 1);
`ifdef CONTADOR_TC_EN
        chk("edge10_tc0", int'(tc0), 0);
`endif
        repeat (8) tick();
        chk("edge18_out0", int'(out0), 9);

        repeat (5) tick();
        chk("pre_hold", int'(out0), 5);
        en = 1'b0;
        repeat (3) tick();
        chk("hold_out0", int'(out0), 5);
        en = 1'b1;
        tick();
        chk("reenable_out0", int'(out0), 6);
        tick();
        chk("pre_rst", int'(out0), 7);

        #3 rst = 1'b1;
        #1;
        chk("async_rst_out0", int'(out0), 0);
        chk("async_rst_out1", int'(out1), 0);
        repeat (2) tick();
        chk("rst_over_en", int'(out0), 0);
        rst = 1'b0;
        tick();
        chk("post_rst_first", int'(out0), 1);
        chk("post_rst_first1", int'(out1), 1);

        for (int i = 0; i < 60; i++) begin
            en = 1'($urandom_range(0, 1));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/contador_rst.md
CONTADOR_RST -- requirements
Module: contador_rst

Interface
REQ-001 Parameter MAX, default 9, terminal count value; legal range 1..(2**WIDTH)-1.
REQ-002 Parameter WIDTH, default 4, bit width of Out.
REQ-003 Clk  input  1  counting clock; all state changes on rising edge (bit-clock of a serial bus, e.g. SCL).
REQ-004 Rst  input  1  reset, asynchronous, active-high; one clock domain (Clk) only.
REQ-005 En  input  1  count enable, sampled on rising Clk.
REQ-006 Out  output  WIDTH  current count, driven directly from the count register.
REQ-007 Tc  output  1  terminal-count flag, present only when CONTADOR_TC_EN is defined.

Function
REQ-008 Count register SHALL update only on rising Clk while Rst is low.
REQ-009 En=0 at a rising edge SHALL hold Out unchanged.
REQ-010 En=1 with Out<MAX SHALL give Out+1 on the next rising edge (latency one edge).
REQ-011 En=1 with Out==MAX SHALL wrap Out to 1, not 0, so each subsequent 9-clock frame (8 data bits + ACK) reaches 8 on its last data bit and MAX on its ACK clock.
REQ-012 Value 0 SHALL occur only after reset; it is never re-entered by counting.
REQ-013 Out>MAX (unreachable in normal operation) SHALL go to 1 on the next enabled edge.
REQ-014 Increment SHALL be WIDTH-bit unsigned; no carry-out is produced.
REQ-015 En change coincident with a rising edge SHALL use the value sampled at that edge.
REQ-016 Tc SHALL be combinational, high exactly while Out==MAX, independent of En.

Reset
REQ-017 Rst=1 SHALL force Out=0 (and Tc=0) immediately, without waiting for Clk.
REQ-018 Rst asserted mid-count SHALL discard the count; Rst overrides En.
REQ-019 After Rst deasserts, the first enabled rising edge SHALL give Out=1.

Configuration
REQ-020 Macro CONTADOR_TC_EN defined: Tc port and logic SHALL exist per REQ-016.
REQ-021 Macro CONTADOR_TC_EN undefined: Tc port SHALL be absent; Out behaviour SHALL be identical.

Structure
REQ-022 Package contador_pkg SHALL hold the default constants CONTADOR_MAX_DEF=9 and CONTADOR_WIDTH_DEF=4; the module parameters default to them.
REQ-023 Implementation SHALL be a single module with no sub-modules; it SHALL include an elaboration-time check that MAX < 2**WIDTH and MAX >= 1.

Verification
REQ-024 Reset then En=1 for 8 rising edges -> Out = 1,2,...,8; Out==8 after the 8th edge.
REQ-025 Continue En=1 -> 9th edge Out=9 (Tc=1 if enabled); 10th edge Out=1; 18th edge Out=9 again.
REQ-026 En=0 for 3 edges at Out=5 -> Out stays 5; re-enable -> 6 on the next edge.
REQ-027 Assert Rst between edges at Out=7 -> Out=0 before the next edge; keep En=1 during Rst -> Out stays 0; release -> 1 on the next edge.
REQ-028 MAX=3, WIDTH=2 override -> sequence 1,2,3,1,2,3; Tc high only at 3; build without CONTADOR_TC_EN -> same Out sequence, no Tc port.
